// File: rtl/key_conditioner.sv
// key_conditioner: synchronise and debounce active-low push-buttons into pressed levels and press/release strobes.
// Define KEY_AUTOREPEAT_EN to add auto-repeat press strobes while a key is held.
module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int SIM_MODE        = 0,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                CLK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY_N,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);
  localparam int DB_RAW    = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DB_CYCLES = SIM_MODE != 0 ? 4 : (DB_RAW < 1 ? 1 : DB_RAW);
  localparam int CW        = $clog2(DB_CYCLES + 1);
  logic [NUM_KEYS-1:0] r_s1, r_s2, r_pressed, r_press, r_rel, w_accept;
  logic [CW-1:0]       r_cnt [NUM_KEYS];
  // The accepted stable raw level is simply ~r_pressed, so s2 == r_pressed means "differs".
  always_comb
    for (int k = 0; k < NUM_KEYS; k++)
      w_accept[k] = (r_s2[k] == r_pressed[k]) && (r_cnt[k] == CW'(DB_CYCLES - 1));
  always_ff @(posedge CLK_50 or negedge RESET_N)
    if (!RESET_N) begin
      r_s1      <= '1;
      r_s2      <= '1;
      r_pressed <= '0;
      r_press   <= '0;
      r_rel     <= '0;
      for (int k = 0; k < NUM_KEYS; k++) r_cnt[k] <= '0;
    end else begin
      r_s1 <= KEY_N;
      r_s2 <= r_s1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_press[k] <= w_accept[k] & ~r_s2[k];
        r_rel[k]   <= w_accept[k] & r_s2[k];
        if (w_accept[k]) r_pressed[k] <= ~r_s2[k];
        r_cnt[k] <= (r_s2[k] != r_pressed[k] || w_accept[k]) ? '0 : r_cnt[k] + 1'b1;
      end
    end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_DELAY = SIM_MODE != 0 ? 8 : CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RPT_RATE  = SIM_MODE != 0 ? 4 : CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int RW        = $clog2(RPT_DELAY + 1);
  logic [RW-1:0]       r_rpt [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_first, r_rpt_pulse;
  always_ff @(posedge CLK_50 or negedge RESET_N)
    if (!RESET_N) begin
      r_first     <= '1;
      r_rpt_pulse <= '0;
      for (int k = 0; k < NUM_KEYS; k++) r_rpt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_accept[k] || !r_pressed[k]) begin
          r_rpt[k]       <= '0;
          r_first[k]     <= 1'b1;
          r_rpt_pulse[k] <= 1'b0;
        end else if (r_rpt[k] == (r_first[k] ? RW'(RPT_DELAY - 1) : RW'(RPT_RATE - 1))) begin
          r_rpt[k]       <= '0;
          r_first[k]     <= 1'b0;
          r_rpt_pulse[k] <= 1'b1;
        end else begin
          r_rpt[k]       <= r_rpt[k] + 1'b1;
          r_rpt_pulse[k] <= 1'b0;
        end
      end
    end
  assign press_pulse = r_press | r_rpt_pulse;
`else
  assign press_pulse = r_press;
`endif
  assign pressed       = r_pressed;
  assign release_pulse = r_rel;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random KEY_N stimulus checked against a sliding-window debounce model.
module tb_key_conditioner;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RR = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic [1:0] pressed, pp, rp;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] h [6];
  logic [1:0] m_pr, m_pp, m_rp;
  int         acc_cyc [2];
  int         cyc = 0;

  always #10 clk = ~clk;

  key_conditioner #(.NUM_KEYS(2), .SIM_MODE(1)) dut (
    .CLK_50(clk), .RESET_N(rst_n), .KEY_N(key_n),
    .pressed(pressed), .press_pulse(pp), .release_pulse(rp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 6; j++) h[j] = 2'b11;
    m_pr = 2'b00;
    m_pp = 2'b00;
    m_rp = 2'b00;
  endtask

  // h[j] is the raw level sampled j edges ago; a change is accepted once the
  // synchronised samples (2..DB+1 edges old) all differ from the accepted level.
  task automatic model_edge();
    logic acc;
    cyc++;
    for (int j = 5; j > 0; j--) h[j] = h[j-1];
    h[0] = key_n;
    m_pp = 2'b00;
    m_rp = 2'b00;
    for (int k = 0; k < 2; k++) begin
      acc = 1'b1;
      for (int j = 2; j < 2 + DB; j++) if (h[j][k] != m_pr[k]) acc = 1'b0;
      if (acc) begin
        m_pr[k] = ~m_pr[k];
        acc_cyc[k] = cyc;
        if (m_pr[k]) m_pp[k] = 1'b1;
        else m_rp[k] = 1'b1;
      end
`ifdef KEY_AUTOREPEAT_EN
      else if (m_pr[k] && cyc - acc_cyc[k] >= RD && (cyc - acc_cyc[k] - RD) % RR == 0) m_pp[k] = 1'b1;
`endif
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".pressed"}, 32'(pressed), 32'(m_pr));
    chk({tag, ".press_pulse"}, 32'(pp), 32'(m_pp));
    chk({tag, ".release_pulse"}, 32'(rp), 32'(m_rp));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".pressed"}, 32'(pressed), 0);
    chk({tag, ".press_pulse"}, 32'(pp), 0);
    chk({tag, ".release_pulse"}, 32'(rp), 0);
  endtask

  task automatic reset_for(input int n, input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero({tag, ".async"});
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_zero(tag);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int idx, cnt, len;
    model_reset();
    reset_for(5, "t1");
    key_n = 2'b10;
    idx = 0;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick("t2");
      if (pp[0] && idx == 0) idx = i;
      cnt += int'(pp[0]);
    end
    chk("t2.latency", idx, 6);
`ifdef KEY_AUTOREPEAT_EN
    chk("t2.pulses", cnt, 8);
`else
    chk("t2.pulses", cnt, 1);
`endif
    key_n = 2'b11;
    idx = 0;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("t4");
      if (rp[0] && idx == 0) idx = i;
      cnt += int'(rp[0]);
    end
    chk("t4.latency", idx, 6);
    chk("t4.pulses", cnt, 1);
    key_n = 2'b10;
    cnt = 0;
    for (int i = 1; i <= 23; i++) begin
      if (i == 4) key_n = 2'b11;
      tick("t3");
      cnt += int'(pp[0]) + int'(rp[0]) + int'(pressed[0]);
    end
    chk("t3.bounce", cnt, 0);
    key_n = 2'b00;
    idx = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("t5a");
      if (pp == 2'b11 && idx == 0) idx = i;
    end
    chk("t5a.both", idx, 6);
    reset_for(3, "t5r");
    idx = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("t5b");
      if (pp == 2'b11 && idx == 0) idx = i;
    end
    chk("t5b.repress", idx, 6);
    key_n = 2'b11;
    for (int i = 0; i < 20; i++) tick("t6s");
    key_n = 2'b01;
    cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      tick("t6");
      cnt += int'(pp[1]);
    end
`ifdef KEY_AUTOREPEAT_EN
    chk("t6.repeats", cnt, 6);
`else
    chk("t6.repeats", cnt, 1);
`endif
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) reset_for($urandom_range(1, 3), "rnd.rst");
      key_n = 2'($urandom);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) tick("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
